// File: rtl/btb_next_pc_pkg.sv
// Shared constants and types for the BTB next-PC generator: word size,
// 2-bit counter encodings and the saturating statistics increment.
package btb_next_pc_pkg;

  localparam int WORD_SIZE = 16;
  localparam int STAT_W    = 16;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt_t;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/btb_next_pc_sat_counter2.sv
// 2-bit saturating direction counter next-state function (combinational).
module sat_counter2
  import btb_next_pc_pkg::*;
(
  input  cnt_t cnt,
  input  logic taken,
  output cnt_t cnt_next
);

  always_comb begin
    // NOTE: default assignment first so every path drives cnt_next; no latch.
    cnt_next = cnt;
    unique case (cnt)
      CNT_SNT: cnt_next = taken ? CNT_WNT : CNT_SNT;
      CNT_WNT: cnt_next = taken ? CNT_WT  : CNT_SNT;
      CNT_WT:  cnt_next = taken ? CNT_ST  : CNT_WNT;
      CNT_ST:  cnt_next = taken ? CNT_ST  : CNT_WT;
      default: cnt_next = cnt;
    endcase
  end

endmodule

// File: rtl/btb_next_pc.sv
// Next-PC generator with a direct-mapped BTB and 2-bit counters.
// Optional statistics counters are enabled by defining BTB_STATS_EN.
module btb_next_pc
  import btb_next_pc_pkg::*;
#(
  parameter int WORD_SIZE    = btb_next_pc_pkg::WORD_SIZE,
  parameter int BTB_IDX_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] pc_cur,
  input  logic                 hazard,
  output logic [WORD_SIZE-1:0] pc_next,
  output logic                 pred_taken,
  input  logic                 update_valid,
  input  logic [WORD_SIZE-1:0] update_pc,
  input  logic                 update_taken,
  input  logic [WORD_SIZE-1:0] update_target,
  input  logic                 mispredict,
  input  logic [WORD_SIZE-1:0] redirect_pc
`ifdef BTB_STATS_EN
  ,
  output logic [STAT_W-1:0]    stat_lookups,
  output logic [STAT_W-1:0]    stat_hits,
  output logic [STAT_W-1:0]    stat_mispredicts
`endif
);

  localparam int ENTRIES  = 1 << BTB_IDX_BITS;
  localparam int TAG_BITS = WORD_SIZE - BTB_IDX_BITS;

  logic                 valid_q  [ENTRIES];
  cnt_t                 cnt_q    [ENTRIES];
  logic [TAG_BITS-1:0]  tag_q    [ENTRIES];
  logic [WORD_SIZE-1:0] target_q [ENTRIES];

  logic [BTB_IDX_BITS-1:0] idx, uidx;
  logic [TAG_BITS-1:0]     ltag, utag;
  logic                    hit, u_hit;
  cnt_t                    cnt_upd;

  assign idx  = pc_cur[BTB_IDX_BITS-1:0];
  assign ltag = pc_cur[WORD_SIZE-1:BTB_IDX_BITS];
  assign uidx = update_pc[BTB_IDX_BITS-1:0];
  assign utag = update_pc[WORD_SIZE-1:BTB_IDX_BITS];

  // Lookup reads the pre-edge table; updates land on the next cycle.
  assign hit        = valid_q[idx] && (tag_q[idx] == ltag);
  assign pred_taken = hit && (cnt_q[idx] inside {CNT_WT, CNT_ST});
  assign u_hit      = valid_q[uidx] && (tag_q[uidx] == utag);

  always_comb begin
    pc_next = pc_cur + WORD_SIZE'(1);
    if (mispredict)      pc_next = redirect_pc;
    else if (pred_taken) pc_next = target_q[idx];
  end

  sat_counter2 u_sat_counter2 (
    .cnt      (cnt_q[uidx]),
    .taken    (update_taken),
    .cnt_next (cnt_upd)
  );

  // NOTE: only valid and cnt need the async clear; tag/target are don't-care
  // while invalid, so they stay as plain unreset storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= CNT_WNT;
      end
    end else if (update_valid) begin
      if (u_hit) begin
        cnt_q[uidx] <= cnt_upd;
      end else if (update_taken) begin
        valid_q[uidx] <= 1'b1;
        cnt_q[uidx]   <= CNT_WT;
      end
    end
  end

  // Taken updates always carry the tag of update_pc, hit or allocate alike.
  always_ff @(posedge clk) begin
    if (update_valid && update_taken) begin
      tag_q[uidx]    <= utag;
      target_q[uidx] <= update_target;
    end
  end

`ifdef BTB_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_lookups     <= '0;
      stat_hits        <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (!hazard) begin
        stat_lookups <= sat_inc(stat_lookups);
        if (hit) stat_hits <= sat_inc(stat_hits);
      end
      if (mispredict) stat_mispredicts <= sat_inc(stat_mispredicts);
    end
  end
`else
  logic unused_hazard;
  assign unused_hazard = hazard;
`endif

endmodule

// File: tb/tb_btb_next_pc.sv
// Self-checking bench for btb_next_pc: directed scenarios plus randomized
// traffic checked against a behavioural table model.
module tb_btb_next_pc;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] pc_cur, update_pc, update_target, redirect_pc, pc_next;
  logic        hazard, update_valid, update_taken, mispredict, pred_taken;
`ifdef BTB_STATS_EN
  logic [15:0] stat_lookups, stat_hits, stat_mispredicts;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  btb_next_pc dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pc_cur        (pc_cur),
    .hazard        (hazard),
    .pc_next       (pc_next),
    .pred_taken    (pred_taken),
    .update_valid  (update_valid),
    .update_pc     (update_pc),
    .update_taken  (update_taken),
    .update_target (update_target),
    .mispredict    (mispredict),
    .redirect_pc   (redirect_pc)
`ifdef BTB_STATS_EN
    ,
    .stat_lookups     (stat_lookups),
    .stat_hits        (stat_hits),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  // Behavioural model: one record per index, counter as a plain 0..3 integer.
  bit m_valid  [256];
  int m_tag    [256];
  int m_target [256];
  int m_cnt    [256];
  int s_lookups, s_hits, s_mp;

  function automatic void m_reset();
    for (int i = 0; i < 256; i++) begin
      m_valid[i] = 1'b0;
      m_cnt[i]   = 1;
    end
    s_lookups = 0;
    s_hits    = 0;
    s_mp      = 0;
  endfunction

  function automatic bit m_hit(int pc);
    return m_valid[pc % 256] && (m_tag[pc % 256] == pc / 256);
  endfunction

  function automatic bit m_pred(int pc);
    return m_hit(pc) && (m_cnt[pc % 256] >= 2);
  endfunction

  function automatic int m_next(int pc, bit mp, int rpc);
    if (mp) return rpc;
    if (m_pred(pc)) return m_target[pc % 256];
    return (pc + 1) % 65536;
  endfunction

  task automatic drive(input logic [15:0] pc, input logic hz, input logic uv,
                       input logic [15:0] upc, input logic ut, input logic [15:0] utgt,
                       input logic mp, input logic [15:0] rpc);
    pc_cur = pc; hazard = hz; update_valid = uv; update_pc = upc;
    update_taken = ut; update_target = utgt; mispredict = mp; redirect_pc = rpc;
  endtask

  // Advance one clock edge and apply the same edge to the model.
  task automatic step();
    int up, ui;
    @(posedge clk);
    if (reset_n) begin
      if (!hazard) begin
        if (s_lookups < 65535) s_lookups++;
        if (m_hit(int'(pc_cur)) && s_hits < 65535) s_hits++;
      end
      if (mispredict && s_mp < 65535) s_mp++;
      if (update_valid) begin
        up = int'(update_pc);
        ui = up % 256;
        if (m_hit(up)) begin
          m_cnt[ui] = update_taken ? ((m_cnt[ui] == 3) ? 3 : m_cnt[ui] + 1)
                                   : ((m_cnt[ui] == 0) ? 0 : m_cnt[ui] - 1);
          if (update_taken) m_target[ui] = int'(update_target);
        end else if (update_taken) begin
          m_valid[ui]  = 1'b1;
          m_tag[ui]    = up / 256;
          m_target[ui] = int'(update_target);
          m_cnt[ui]    = 2;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    m_reset();
    drive(16'h0010, 0, 0, 0, 0, 0, 0, 0);
    #2;
    if (pc_next !== 16'h0011 || pred_taken !== 1'b0) begin
      miscompares++; $display("FAIL reset_lookup: got %h/%b want 0011/0", pc_next, pred_taken);
    end
    vectors++;
    drive(16'hFFFF, 0, 0, 0, 0, 0, 0, 0);
    #2;
    if (pc_next !== 16'h0000) begin
      miscompares++; $display("FAIL reset_wrap: got %h want 0000", pc_next);
    end
    vectors++;
    drive(16'h0010, 0, 0, 0, 0, 0, 1, 16'h1234);
    #2;
    if (pc_next !== 16'h1234) begin
      miscompares++; $display("FAIL reset_redirect: got %h want 1234", pc_next);
    end
    vectors++;
    step();
    #1 reset_n = 1'b1;
    drive(16'hFFFF, 0, 0, 0, 0, 0, 0, 0);
    #2;
    if (pc_next !== 16'h0000 || pred_taken !== 1'b0) begin
      miscompares++; $display("FAIL wrap: got %h/%b want 0000/0", pc_next, pred_taken);
    end
    vectors++;
    step();
  endtask

  task automatic test_train_taken();
    // Same-cycle lookup of the entry being trained sees the old contents.
    drive(16'h0010, 0, 1, 16'h0010, 1, 16'h0040, 0, 0);
    #2;
    if (pc_next !== 16'h0011 || pred_taken !== 1'b0) begin
      miscompares++; $display("FAIL no_bypass: got %h/%b want 0011/0", pc_next, pred_taken);
    end
    vectors++;
    step();
    drive(16'h0010, 0, 0, 0, 0, 0, 0, 0);
    #2;
    if (pc_next !== 16'h0040 || pred_taken !== 1'b1) begin
      miscompares++; $display("FAIL train_taken: got %h/%b want 0040/1", pc_next, pred_taken);
    end
    vectors++;
    step();
  endtask

  task automatic test_counter_decay();
    logic [15:0] exp_next [5] = '{16'h0040, 16'h0011, 16'h0011, 16'h0011, 16'h0011};
    logic        exp_pred [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        upd_t    [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    // cnt before each lookup: 10, 01, 00, 00 (floored), 01; then 10.
    for (int k = 0; k < 5; k++) begin
      drive(16'h0010, 0, 1, 16'h0010, upd_t[k], 16'h0040, 0, 0);
      #2;
      if (pc_next !== exp_next[k] || pred_taken !== exp_pred[k]) begin
        miscompares++;
        $display("FAIL decay_%0d: got %h/%b want %h/%b", k, pc_next, pred_taken, exp_next[k], exp_pred[k]);
      end
      vectors++;
      step();
    end
    drive(16'h0010, 0, 0, 0, 0, 0, 0, 0);
    #2;
    if (pc_next !== 16'h0040 || pred_taken !== 1'b1) begin
      miscompares++; $display("FAIL decay_retrain: got %h/%b want 0040/1", pc_next, pred_taken);
    end
    vectors++;
    step();
  endtask

  task automatic test_alias_replace();
    drive(16'h0110, 0, 0, 0, 0, 0, 0, 0);
    #2;
    if (pc_next !== 16'h0111 || pred_taken !== 1'b0) begin
      miscompares++; $display("FAIL alias_miss: got %h/%b want 0111/0", pc_next, pred_taken);
    end
    vectors++;
    step();
    drive(16'h0000, 0, 1, 16'h0110, 1, 16'h0300, 0, 0);
    step();
    drive(16'h0110, 0, 0, 0, 0, 0, 0, 0);
    #2;
    if (pc_next !== 16'h0300 || pred_taken !== 1'b1) begin
      miscompares++; $display("FAIL alias_replace: got %h/%b want 0300/1", pc_next, pred_taken);
    end
    vectors++;
    step();
    drive(16'h0010, 0, 0, 0, 0, 0, 0, 0);
    #2;
    if (pc_next !== 16'h0011 || pred_taken !== 1'b0) begin
      miscompares++; $display("FAIL alias_evicted: got %h/%b want 0011/0", pc_next, pred_taken);
    end
    vectors++;
    step();
  endtask

  task automatic test_mispredict();
    drive(16'h0000, 0, 1, 16'h0010, 1, 16'h0040, 0, 0);
    step();
    drive(16'h0010, 0, 1, 16'h0010, 1, 16'h0050, 1, 16'h0200);
    #2;
    if (pc_next !== 16'h0200 || pred_taken !== 1'b1) begin
      miscompares++; $display("FAIL redirect: got %h/%b want 0200/1", pc_next, pred_taken);
    end
    vectors++;
    step();
    // cnt is now 11, so one not-taken update still predicts taken.
    drive(16'h0010, 0, 1, 16'h0010, 0, 16'h0000, 0, 0);
    #2;
    if (pc_next !== 16'h0050 || pred_taken !== 1'b1) begin
      miscompares++; $display("FAIL redirect_update: got %h/%b want 0050/1", pc_next, pred_taken);
    end
    vectors++;
    step();
    drive(16'h0010, 0, 0, 0, 0, 0, 0, 0);
    #2;
    if (pc_next !== 16'h0050 || pred_taken !== 1'b1) begin
      miscompares++; $display("FAIL redirect_strong: got %h/%b want 0050/1", pc_next, pred_taken);
    end
    vectors++;
    step();
  endtask

  function automatic logic [15:0] rand_pc();
    if ($urandom_range(0, 30) == 0) return 16'hFFFF;
    return 16'(($urandom_range(0, 3) << 8) | $urandom_range(0, 7));
  endfunction

  task automatic test_random();
    logic [15:0] pc, upc, utgt, rpc, exp_next;
    logic        hz, uv, ut, mp, exp_pred;
    for (int n = 0; n < 400; n++) begin
      pc   = rand_pc();
      upc  = rand_pc();
      utgt = 16'($urandom_range(0, 65535));
      rpc  = 16'($urandom_range(0, 65535));
      hz   = ($urandom_range(0, 3) == 0);
      uv   = ($urandom_range(0, 1) == 1);
      ut   = ($urandom_range(0, 9) < 6);
      mp   = ($urandom_range(0, 9) == 0);
      drive(pc, hz, uv, upc, ut, utgt, mp, rpc);
      #2;
      exp_next = 16'(m_next(int'(pc), mp, int'(rpc)));
      exp_pred = m_pred(int'(pc));
      if (pc_next !== exp_next || pred_taken !== exp_pred) begin
        miscompares++;
        $display("FAIL random_%0d pc=%h: got %h/%b want %h/%b", n, pc, pc_next, pred_taken, exp_next, exp_pred);
      end
      vectors++;
      step();
    end
`ifdef BTB_STATS_EN
    if (stat_lookups !== 16'(s_lookups) || stat_hits !== 16'(s_hits) || stat_mispredicts !== 16'(s_mp)) begin
      miscompares++;
      $display("FAIL random_stats: got %0d/%0d/%0d want %0d/%0d/%0d", stat_lookups, stat_hits,
               stat_mispredicts, s_lookups, s_hits, s_mp);
    end
    vectors++;
`endif
  endtask

  task automatic test_async_reset();
    drive(16'h0000, 0, 1, 16'h0010, 1, 16'h0040, 0, 0);
    step();
    drive(16'h0010, 0, 0, 0, 0, 0, 0, 0);
    #2;
    if (pc_next !== 16'h0040 || pred_taken !== 1'b1) begin
      miscompares++; $display("FAIL pre_reset_hit: got %h/%b want 0040/1", pc_next, pred_taken);
    end
    vectors++;
    #1 reset_n = 1'b0;
    m_reset();
    #1;
    if (pc_next !== 16'h0011 || pred_taken !== 1'b0) begin
      miscompares++; $display("FAIL async_reset: got %h/%b want 0011/0", pc_next, pred_taken);
    end
    vectors++;
    // This update spans an edge while reset is held and must be dropped.
    drive(16'h0010, 0, 1, 16'h0010, 1, 16'h0070, 0, 0);
    step();
    #2 reset_n = 1'b1;
    drive(16'h0010, 0, 0, 0, 0, 0, 0, 0);
    #1;
    if (pc_next !== 16'h0011 || pred_taken !== 1'b0) begin
      miscompares++; $display("FAIL reset_dropped_update: got %h/%b want 0011/0", pc_next, pred_taken);
    end
    vectors++;
    step();
    drive(16'h0110, 0, 0, 0, 0, 0, 0, 0);
    #2;
    if (pc_next !== 16'h0111 || pred_taken !== 1'b0) begin
      miscompares++; $display("FAIL reset_alias_miss: got %h/%b want 0111/0", pc_next, pred_taken);
    end
    vectors++;
    step();
  endtask

`ifdef BTB_STATS_EN
  task automatic test_stats();
    drive(16'h0000, 1, 0, 0, 0, 0, 0, 0);
    #1 reset_n = 1'b0;
    m_reset();
    #1;
    if (stat_lookups !== 16'd0 || stat_hits !== 16'd0 || stat_mispredicts !== 16'd0) begin
      miscompares++;
      $display("FAIL stats_reset: got %0d/%0d/%0d want 0/0/0", stat_lookups, stat_hits, stat_mispredicts);
    end
    vectors++;
    step();
    #2 reset_n = 1'b1;
    drive(16'h0000, 1, 1, 16'h0010, 1, 16'h0040, 0, 0);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(16'h0010, 0, 0, 0, 0, 0, 0, 0);
      step();
    end
    drive(16'h0010, 1, 0, 0, 0, 0, 0, 0);
    step();
    if (stat_lookups !== 16'd3 || stat_hits !== 16'd3 || stat_mispredicts !== 16'd0) begin
      miscompares++;
      $display("FAIL stats_hits: got %0d/%0d/%0d want 3/3/0", stat_lookups, stat_hits, stat_mispredicts);
    end
    vectors++;
    drive(16'h0010, 1, 0, 0, 0, 0, 1, 16'h0100);
    step();
    if (stat_lookups !== 16'd3 || stat_mispredicts !== 16'd1) begin
      miscompares++;
      $display("FAIL stats_mispredict: got %0d/%0d want 3/1", stat_lookups, stat_mispredicts);
    end
    vectors++;
  endtask
`endif

  initial begin
    test_reset();
    test_train_taken();
    test_counter_decay();
    test_alias_replace();
    test_mispredict();
    test_random();
    test_async_reset();
`ifdef BTB_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/btb_next_pc.md
# btb_next_pc

Next-PC generator for the pipelined 16-bit CPU. Sits directly upstream of the PC register: it takes the current fetch PC, looks it up in a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, and produces the PC the register loads on the next non-stalled edge. It is trained by resolved branches and jumps from EX, and it applies EX mispredict redirects with top priority.

## Interface
Parameters:
- `WORD_SIZE`, 16: address/data width; the value comes from `macro.v`.
- `BTB_IDX_BITS`, 8: index width. The BTB has 2^`BTB_IDX_BITS` entries. Tag width is `WORD_SIZE` − `BTB_IDX_BITS`.

Ports:
- `clk`  in  1  single clock; all state updates on the posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pc_cur`  in  16  current fetch PC, from the PC register.
- `hazard`  in  1  stall indicator, same meaning as at the PC register. Used only by the statistics logic.
- `pc_next`  out  16  next PC, to the PC register.
- `pred_taken`  out  1  prediction flag; carried down the pipeline alongside the fetched instruction.
- `update_valid`  in  1  EX has resolved a branch or jump this cycle.
- `update_pc`  in  16  PC of the resolved instruction.
- `update_taken`  in  1  actual direction of the resolved instruction.
- `update_target`  in  16  actual taken target of the resolved instruction.
- `mispredict`  in  1  EX redirect request.
- `redirect_pc`  in  16  correct PC to load on a redirect.

## Operation
Each entry holds: `valid`, `tag`, `target[15:0]`, `cnt[1:0]`.

Lookup (combinational):
- `idx` = `pc_cur[BTB_IDX_BITS-1:0]`.
- Hit = `valid` && `tag` == `pc_cur[15:BTB_IDX_BITS]`.
- `pred_taken` = hit && `cnt[1]`.

`pc_next` priority:
1. `mispredict` → `redirect_pc`.
2. `pred_taken` → entry `target`.
3. Otherwise → `pc_cur` + 1. The +1 is word-addressed, modulo 2^16, so 0xFFFF wraps to 0x0000.

Update (posedge, when `update_valid`), with `uidx` taken from `update_pc`:
- **Tag match:** `cnt` saturating ±1 (taken +1, capped at 11; not-taken −1, floored at 00). If taken, `target` ← `update_target`.
- **Tag miss or invalid, taken:** allocate/replace the entry: `valid`=1, new tag, `target` ← `update_target`, `cnt`=10.
- **Tag miss or invalid, not-taken:** no write.

Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.

Reset:
- All `valid`=0 and all `cnt`=01. Stats counters = 0.
- Outputs during reset: `pred_taken`=0 and `pc_next`=`pc_cur`+1. `mispredict` still overrides.

## Timing
- Lookup latency is 0 cycles: `pc_next` and `pred_taken` are combinational from `pc_cur`, table state, and the redirect inputs.
- An update becomes visible to lookups on the cycle after its edge.
- Lookup and update to the same index in the same cycle: the lookup sees the pre-update contents. There is no bypass.
- `hazard` does not gate updates or redirects. The PC register alone decides whether `pc_next` is loaded.
- `reset_n` falling mid-cycle clears the table immediately, without waiting for a clock edge. An update pending at that time is discarded.
- `mispredict` and `update_valid` in the same cycle: the redirect drives `pc_next` and the update is still written.

## Configuration
- `BTB_STATS_EN` defined: adds output ports `stat_lookups`, `stat_hits`, `stat_mispredicts`, each 16 bits and saturating at 0xFFFF.
  - On each posedge with `reset_n`=1 and `hazard`=0: `stat_lookups` +1; `stat_hits` +1 if hit.
  - On each posedge with `mispredict`=1: `stat_mispredicts` +1, regardless of `hazard`.
- `BTB_STATS_EN` undefined: these ports and their counters are absent. Prediction behaviour is identical in both builds.

## Structure
- `macro.v` holds `WORD_SIZE`, the counter encodings (`CNT_SNT`, `CNT_WNT`, `CNT_WT`, `CNT_ST`) and the `BTB_STATS_EN` default.
- Sub-module `sat_counter2`: combinational 2-bit saturating next-state function with inputs `cnt` and `taken`, output `cnt_next`. Instantiated once, on the update path.

## Test plan
- Reset, then `pc_cur`=0x0010 → `pc_next`=0x0011, `pred_taken`=0. With `pc_cur`=0xFFFF → `pc_next`=0x0000.
- Update at 0x0010, taken, target 0x0040. Next cycle `pc_cur`=0x0010 → `pc_next`=0x0040, `pred_taken`=1 (`cnt`=10).
- Two not-taken updates at 0x0010 → `cnt` goes 10→01→00. After the first update, lookup gives `pc_next`=0x0011 and `pred_taken`=0. A further not-taken update holds `cnt` at 00.
- With 0x0010 trained taken, `pc_cur`=0x0110 (same index, different tag) → `pc_next`=0x0111. A taken update at 0x0110 with target 0x0300 replaces the entry, so 0x0010 then misses.
- `pc_cur`=0x0010 hitting taken, with `mispredict`=1 and `redirect_pc`=0x0200 → `pc_next`=0x0200. A same-cycle update at 0x0010 is still written.
- Async `reset_n` pulse between edges → `pred_taken` drops immediately and all entries miss. With `BTB_STATS_EN`: 3 unstalled hits plus 1 stalled cycle → `stat_lookups`=3, `stat_hits`=3.
